regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine on the register-file side of the datapath. On a start pulse it walks the register file's A-port select address over a configured register range and snapshots each 64-bit register. It then streams each snapshot as four 16-bit halfwords over a valid/ready handshake to the GPIO/serial debug path. It reuses the existing SA/A read port, so the 16-bit display taps stay untouched.

## Interface
Parameters:
- FIRST_REG, 0, first register index dumped (0..31)
- LAST_REG, 30, last register index dumped; must be >= FIRST_REG (R31 reads constant zero, so it is excluded by default)

Ports:
- clock  input  1  posedge clock
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  input  1  begin a dump; sampled only in IDLE
- A  input  64  register-file A bus, combinational function of SA
- SA  output  5  register-file A select address
- out_data  output  16  current halfword
- out_tag  output  7  {register index[4:0], halfword index[1:0]}
- out_valid  output  1  out_data/out_tag valid
- out_ready  input  1  sink accepts when high together with out_valid
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when dump completes

## Operation
- States: IDLE, LOAD, SEND, CSUM (macro only), DONE.
- IDLE: busy=0, out_valid=0. On start=1, go to LOAD with reg_idx=FIRST_REG and hw_idx=0.
- LOAD: SA=reg_idx. At the clock edge, latch A into a 64-bit snapshot, then go to SEND.
- SEND: out_valid=1, out_data=snapshot[16*hw_idx+15:16*hw_idx] (low halfword first), out_tag={reg_idx,hw_idx}.
- Transfer occurs on the edge where out_valid && out_ready. No transfer: outputs hold stable, state unchanged.
- After a transfer with hw_idx<3: hw_idx+1.
- After a transfer with hw_idx==3: hw_idx=0. If reg_idx==LAST_REG, go to CSUM (macro) or DONE; else reg_idx+1 and go to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE.
- SA holds the last driven index outside LOAD.
- start is ignored while busy. Register writes during a dump are allowed; each register is snapshotted at its own LOAD edge.
- Reset (any state, mid-handshake included): immediately IDLE. SA=0, out_data=0, out_tag=0, out_valid=0, busy=0, done=0, reg_idx=FIRST_REG, hw_idx=0, checksum=0. A partially sent register is never resumed.

## Timing
- start sampled at edge k → LOAD during cycle k+1 (busy=1, SA=FIRST_REG) → out_valid=1 from cycle k+2.
- With out_ready held high: 5 cycles per register (1 LOAD + 4 SEND).
- Default range (31 registers): 155 cycles from LOAD entry to the last transfer, then done one cycle later (one further cycle with CSUM). busy falls the cycle after done.
- out_valid never drops without a transfer. No combinational path from out_ready to out_valid/out_data.

## Configuration
- REGFILE_DUMP_CHECKSUM_EN defined: after the last register, state CSUM presents out_data = XOR of every halfword transferred in this dump, with out_tag=7'h7F and the same handshake. Then DONE. Checksum is cleared on leaving IDLE.
- Undefined: no CSUM state and no checksum register. DONE follows the last register's halfword 3 directly.

## Structure
- Shared package: state encoding (IDLE/LOAD/SEND/CSUM/DONE), the CSUM tag constant 7'h7F, and the halfword width constant 16.
- One natural sub-module: regfile_dump_snapshot. It is a 64-bit load register with a halfword select and a 2-bit halfword counter.

## Test plan
- Reset mid-SEND (out_valid=1, tag {5,2}) → same cycle: out_valid=0, busy=0, SA=0. Next start restarts at tag {0,0}.
- Registers Rn=64'h0n0n_1111_2222_3333 model, ready always high, start → tags {0,0}..{30,3} in order. R5 yields 3333, 2222, 1111, 0505. done exactly 156 cycles after start sampled.
- out_ready low for 3 cycles during tag {2,1} → out_data/out_tag frozen for all 3 cycles, no skipped or duplicated tag.
- FIRST_REG=LAST_REG=31 → four halfwords all 16'h0000, then done.
- Write R3=64'hDEAD_BEEF_0000_0001 while dumping R1 → R3 dump reflects the new value. start pulsed while busy is ignored.
- With REGFILE_DUMP_CHECKSUM_EN, FIRST=LAST=5, R5=64'h0001_0002_0004_0008 → extra word with tag 7'h7F, data 16'h000F.

Source files
------------

// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared state encoding and constants for the register-file dump engine.
// Revision 1.0
`default_nettype none

package regfile_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_SEND = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int         HW_W     = 16;
   localparam logic [6:0] CSUM_TAG = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/regfile_dump_snapshot.sv
// regfile_dump_snapshot: 64-bit snapshot register with a 2-bit halfword counter and halfword select.
// Revision 1.0
`default_nettype none

module regfile_dump_snapshot
   import regfile_dump_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            advance,
   input  logic [63:0]     data_in,
   output logic [HW_W-1:0] hw_data,
   output logic [1:0]      hw_idx,
   output logic            last_hw
);

   logic [63:0] snap;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         snap   <= '0;
         hw_idx <= 2'd0;
      end else if (load) begin
         snap   <= data_in;
         hw_idx <= 2'd0;
      end else if (advance) begin
         hw_idx <= hw_idx + 2'd1;   // wraps to 0 after halfword 3
      end
   end

   assign hw_data = snap[HW_W*hw_idx +: HW_W];
   assign last_hw = (hw_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/regfile_dump.sv
// regfile_dump: walks the RF A-port over [FIRST_REG..LAST_REG] and streams each register as 4 halfwords.
// Optional trailing XOR checksum word enabled by defining REGFILE_DUMP_CHECKSUM_EN. Revision 1.0
`default_nettype none

module regfile_dump
   import regfile_dump_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 30
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [63:0]     A,
   output logic [4:0]      SA,
   output logic [HW_W-1:0] out_data,
   output logic [6:0]      out_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic            done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   state_t          state, state_next;
   logic [4:0]      reg_idx;
   logic            snap_load, snap_advance, last_hw, last_reg, xfer;
   logic [1:0]      hw_idx;
   logic [HW_W-1:0] hw_data;

   assign last_reg = (reg_idx == LAST_IDX);
   assign xfer     = out_valid && out_ready;

   regfile_dump_snapshot u_snapshot (
      .clock   (clock),
      .reset   (reset),
      .load    (snap_load),
      .advance (snap_advance),
      .data_in (A),
      .hw_data (hw_data),
      .hw_idx  (hw_idx),
      .last_hw (last_hw)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // SA only moves when a new register is about to be loaded, so it holds elsewhere
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         reg_idx <= FIRST_IDX;
         SA      <= 5'd0;
      end else if (state == ST_IDLE && start) begin
         reg_idx <= FIRST_IDX;
         SA      <= FIRST_IDX;
      end else if (state == ST_SEND && xfer && last_hw && !last_reg) begin
         reg_idx <= reg_idx + 5'd1;
         SA      <= reg_idx + 5'd1;
      end
   end

`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [HW_W-1:0] checksum;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                            checksum <= '0;
      else if (state == ST_IDLE && start)   checksum <= '0;
      else if (state == ST_SEND && xfer)    checksum <= checksum ^ hw_data;
   end
`endif

   always_comb begin
      state_next   = state;
      snap_load    = 1'b0;
      snap_advance = 1'b0;
      out_valid    = 1'b0;
      out_data     = '0;
      out_tag      = 7'd0;
      done         = 1'b0;
      busy         = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            snap_load  = 1'b1;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            out_valid = 1'b1;
            out_data  = hw_data;
            out_tag   = {reg_idx, hw_idx};
            if (out_ready) begin
               snap_advance = 1'b1;
               if (last_hw) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  state_next = last_reg ? ST_CSUM : ST_LOAD;
`else
                  state_next = last_reg ? ST_DONE : ST_LOAD;
`endif
               end
            end
         end
`ifdef REGFILE_DUMP_CHECKSUM_EN
         ST_CSUM: begin
            out_valid = 1'b1;
            out_data  = checksum;
            out_tag   = CSUM_TAG;
            if (out_ready) state_next = ST_DONE;
         end
`endif
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: scoreboard bench for regfile_dump with a register-file model and random handshake stalls.
// Revision 1.0
`default_nettype none

module tb_regfile_dump;

   localparam logic [6:0] CSUM_T = 7'h7F;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   localparam int DONE_LAT = 157;
   localparam int NW2      = 5;
`else
   localparam int DONE_LAT = 156;
   localparam int NW2      = 4;
`endif

   typedef struct packed {
      logic [6:0]  tag;
      logic [15:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset, start, out_ready;
   logic [63:0] A;
   logic [4:0]  SA;
   logic [15:0] out_data;
   logic [6:0]  out_tag;
   logic        out_valid, busy, done;

   logic        start2;
   logic        ready2 = 1'b1;
   logic [63:0] A2;
   logic [4:0]  SA2;
   logic [15:0] data2;
   logic [6:0]  tag2;
   logic        valid2, busy2, done2;

   logic [63:0] rf [32];
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        prev_stall = 1'b0;

   always #5 clock = ~clock;

   assign A  = rf[SA];
   assign A2 = rf[SA2];

   regfile_dump dut (
      .clock(clock), .reset(reset), .start(start), .A(A), .SA(SA),
      .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   regfile_dump #(.FIRST_REG(31), .LAST_REG(31)) dut_r31 (
      .clock(clock), .reset(reset), .start(start2), .A(A2), .SA(SA2),
      .out_data(data2), .out_tag(tag2), .out_valid(valid2),
      .out_ready(ready2), .busy(busy2), .done(done2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected stream: every register's value as it stands now, low halfword first
   task automatic push_dump();
      exp_t        e;
      logic [15:0] cs;
      cs = '0;
      for (int r = 0; r <= 30; r++) begin
         for (int h = 0; h < 4; h++) begin
            e.tag  = {5'(r), 2'(h)};
            e.data = rf[r][16*h +: 16];
            cs     = cs ^ e.data;
            exp_q.push_back(e);
         end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      e.tag  = CSUM_T;
      e.data = cs;
      exp_q.push_back(e);
`endif
   endtask

   // A register written before it is loaded must be dumped with its new value
   task automatic rewrite_reg(input int r);
      logic [15:0] nd;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      logic [15:0] delta;
      delta = '0;
`endif
      foreach (exp_q[i]) begin
         if (exp_q[i].tag != CSUM_T && exp_q[i].tag[6:2] == 5'(r)) begin
            nd = rf[r][16*int'(exp_q[i].tag[1:0]) +: 16];
`ifdef REGFILE_DUMP_CHECKSUM_EN
            delta = delta ^ exp_q[i].data ^ nd;
`endif
            exp_q[i].data = nd;
         end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      exp_q[exp_q.size()-1].data = exp_q[exp_q.size()-1].data ^ delta;
`endif
   endtask

   task automatic kick();
      push_dump();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("load_busy",  32'(busy),      32'd1);
      check("load_sa",    32'(SA),        32'd0);
      check("load_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic wait_done(input bit rnd, output int cycles);
      cycles = 1;
      while (!done && cycles < 3000) begin
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clock); #1;
         cycles++;
      end
      check("done_reached", 32'(done), 32'd1);
      out_ready = 1'b1;
      @(posedge clock); #1;
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   task automatic wait_tag(input logic [6:0] t);
      int n;
      n = 0;
      while (!(out_valid && out_tag == t) && n < 1000) begin
         @(posedge clock); #1;
         n++;
      end
      check("reach_tag", 32'(out_tag), 32'(t));
   endtask

   // Monitor: every presented word is compared with the scoreboard head
   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("valid_held", 32'(out_valid), 32'd1);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 32'(out_valid), 32'd0);
            end else begin
               check("tag",  32'(out_tag),  32'(exp_q[0].tag));
               check("data", 32'(out_data), 32'(exp_q[0].data));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         if (done) check("done_queue_empty", 32'(exp_q.size()), 32'd0);
         prev_stall = out_valid && !out_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d words still expected", exp_q.size());
      $fatal(1);
   end

   initial begin
      int cyc, k, n;
      logic [6:0] t2;
      reset = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b0;
      for (int r = 0; r < 32; r++) rf[r] = '0;
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_sa",    32'(SA),        32'd0);
      check("rst_data",  32'(out_data),  32'd0);
      check("rst_tag",   32'(out_tag),   32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock); #1;

      // Patterned registers, sink always ready, done latency
      for (int r = 0; r <= 30; r++) rf[r] = {8'(r), 8'(r), 48'h1111_2222_3333};
      out_ready = 1'b1;
      kick();
      wait_done(1'b0, cyc);
      check("done_latency", 32'(cyc), 32'(DONE_LAT));

      // Write R3 while R1 streams, start pulse while busy, 3-cycle stall on {2,1}
      kick();
      wait_tag({5'd1, 2'd0});
      rf[3] = 64'hDEAD_BEEF_0000_0001;
      rewrite_reg(3);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      wait_tag({5'd2, 2'd1});
      out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 out_ready = 1'b1;
      wait_done(1'b0, cyc);

      // Random contents with random sink back-pressure
      for (int d = 0; d < 3; d++) begin
         for (int r = 0; r <= 30; r++) rf[r] = {$urandom, $urandom};
         kick();
         wait_done(1'b1, cyc);
      end

      // Asynchronous reset while {5,2} is on the bus, then a clean restart
      kick();
      wait_tag({5'd5, 2'd2});
      @(negedge clock); #2;
      reset = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy",  32'(busy),      32'd0);
      check("midrst_sa",    32'(SA),        32'd0);
      check("midrst_tag",   32'(out_tag),   32'd0);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      check("post_rst_idle", 32'(busy), 32'd0);
      kick();
      @(posedge clock); #1;
      check("restart_tag",   32'(out_tag),   32'd0);
      check("restart_valid", 32'(out_valid), 32'd1);
      wait_done(1'b0, cyc);

      // Single-register instance on the hard-wired zero register
      start2 = 1'b1;
      @(posedge clock); #1;
      start2 = 1'b0;
      k = 0; n = 0;
      while (!done2 && n < 100) begin
         if (valid2) begin
            t2 = (k < 4) ? {5'd31, 2'(k)} : CSUM_T;
            check("r31_tag",  32'(tag2),  32'(t2));
            check("r31_data", 32'(data2), 32'd0);
            k++;
         end
         @(posedge clock); #1;
         n++;
      end
      check("r31_done",  32'(done2), 32'd1);
      check("r31_words", 32'(k),     32'(NW2));
      @(posedge clock); #1;
      check("r31_busy_after", 32'(busy2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
